// File: rtl/spoofer_pkg.sv
// rtl/spoofer_pkg.sv - shared types and constants for the spoofer core
package spoofer_pkg;

    localparam int SPOOFER_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        REQ,
        SETTLE
    } spoofer_src_state_t;

endpackage

// File: rtl/spoofer_delay_timer.sv
// rtl/spoofer_delay_timer.sv - loadable down-counter, done while count is zero
module spoofer_delay_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/spoofer_avst_source.sv
// rtl/spoofer_avst_source.sv - samples the counter and streams it as packetised AVST beats
module spoofer_avst_source
    import spoofer_pkg::*;
#(
    parameter int DATA_WIDTH    = SPOOFER_DATA_WIDTH,
    parameter int PACKET_LEN    = 4,
    parameter int REQ_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    count_in,
    output logic                     read_signal,
    output logic [DATA_WIDTH-1:0]    aso_data,
    output logic                     aso_valid,
    input  logic                     aso_ready,
    output logic                     aso_startofpacket,
    output logic                     aso_endofpacket,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count,
    output logic                     busy
);

    localparam int IDX_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int TMR_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_LEN - 1);

    if (PACKET_LEN < 1) begin : g_bad_packet_len
        $error("PACKET_LEN must be at least 1");
    end
    if (REQ_CYCLES < 1) begin : g_bad_req_cycles
        $error("REQ_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES < 2) begin : g_bad_settle_cycles
        $error("SETTLE_CYCLES must be at least 2");
    end

    spoofer_src_state_t state, state_d;

    logic [IDX_W-1:0]         idx, idx_d;
    logic [DATA_WIDTH-1:0]    data_d;
    logic                     valid_d, sop_d, eop_d, read_d, busy_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_d;
    logic                     tmr_load, tmr_done;
    logic [TMR_W-1:0]         tmr_value;

    // Timers are loaded with N-1 so the state lasts exactly N cycles.
    spoofer_delay_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_value(tmr_value),
        .done      (tmr_done)
    );

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        data_d    = aso_data;
        valid_d   = aso_valid;
        sop_d     = aso_startofpacket;
        eop_d     = aso_endofpacket;
        read_d    = read_signal;
        pkt_d     = pkt_count;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = count_in;
                sop_d   = (idx == '0);
                eop_d   = (idx == LAST_IDX);
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (aso_ready) begin
                    valid_d   = 1'b0;
                    read_d    = 1'b1;
                    idx_d     = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                    if (aso_endofpacket) begin
                        pkt_d = pkt_count + PKT_CNT_WIDTH'(1);
                    end
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(REQ_CYCLES - 1);
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (tmr_done) begin
                    read_d    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SETTLE_CYCLES - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                // A started packet always runs to eop; enable only gates packet starts.
                if (tmr_done) begin
                    state_d = ((idx != '0) || enable) ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            idx               <= '0;
            aso_data          <= '0;
            aso_valid         <= 1'b0;
            aso_startofpacket <= 1'b0;
            aso_endofpacket   <= 1'b0;
            read_signal       <= 1'b0;
            pkt_count         <= '0;
            busy              <= 1'b0;
        end else begin
            state             <= state_d;
            idx               <= idx_d;
            aso_data          <= data_d;
            aso_valid         <= valid_d;
            aso_startofpacket <= sop_d;
            aso_endofpacket   <= eop_d;
            read_signal       <= read_d;
            pkt_count         <= pkt_d;
            busy              <= busy_d;
        end
    end

endmodule

// File: tb/tb_spoofer_avst_source.sv
// tb/tb_spoofer_avst_source.sv - scoreboard bench for spoofer_avst_source
module tb_spoofer_avst_source;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, ready;
    logic        read_signal, valid, sop, eop, busy;
    logic [31:0] data, count_in;
    logic [15:0] pkt_count;

    logic        enable2;
    logic        ready2;
    logic        read2, valid2, sop2, eop2, busy2;
    logic [31:0] data2, count_in2;
    logic [3:0]  pkt_count2;

    logic [23:0] cnt, cnt2;
    logic [2:0]  sync, sync2;
    logic        preload_en;
    logic [23:0] preload_val;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    beats_seen = 0;
    int    beats2 = 0;

    always #5 clk = ~clk;

    assign count_in  = {8'd0, cnt};
    assign count_in2 = {8'd0, cnt2};

    spoofer_avst_source #(
        .DATA_WIDTH(32), .PACKET_LEN(4), .REQ_CYCLES(2), .SETTLE_CYCLES(3), .PKT_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .count_in(count_in),
        .read_signal(read_signal), .aso_data(data), .aso_valid(valid), .aso_ready(ready),
        .aso_startofpacket(sop), .aso_endofpacket(eop), .pkt_count(pkt_count), .busy(busy)
    );

    spoofer_avst_source #(
        .DATA_WIDTH(32), .PACKET_LEN(1), .REQ_CYCLES(2), .SETTLE_CYCLES(3), .PKT_CNT_WIDTH(4)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .count_in(count_in2),
        .read_signal(read2), .aso_data(data2), .aso_valid(valid2), .aso_ready(ready2),
        .aso_startofpacket(sop2), .aso_endofpacket(eop2), .pkt_count(pkt_count2), .busy(busy2)
    );

    // 24-bit counter models: read request passes a 2-flop sync, rising edge increments.
    always @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sync <= '0;
        end else begin
            sync <= {sync[1:0], read_signal};
            if (preload_en)
                cnt <= preload_val;
            else if (sync[1] && !sync[2])
                cnt <= cnt + 24'd1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt2  <= '0;
            sync2 <= '0;
        end else begin
            sync2 <= {sync2[1:0], read2};
            if (sync2[1] && !sync2[2])
                cnt2 <= cnt2 + 24'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        exp_q.push_back(b);
    endtask

    // Monitor: pops the scoreboard on every handshake of the main DUT.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h with nothing expected", data);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_data", data, b.data);
                check("beat_sop", 32'(sop), 32'(b.sop));
                check("beat_eop", 32'(eop), 32'(b.eop));
            end
            beats_seen++;
        end
    end

    always @(negedge clk) begin
        if (!rst && valid2 && ready2) begin
            check("len1_data", data2, beats2);
            check("len1_sop", 32'(sop2), 32'd1);
            check("len1_eop", 32'(eop2), 32'd1);
            beats2++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        for (int i = 0; i < 300 && beats_seen < target; i++) step();
        check("beat_timeout", 32'(beats_seen >= target), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) step();
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !valid; i++) step();
        check("valid_timeout", 32'(valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ready = 1'b0;
        enable2 = 1'b0; ready2 = 1'b1;
        preload_en = 1'b0; preload_val = '0;
        repeat (3) step();

        check("rst_valid", 32'(valid), 32'd0);
        check("rst_read", 32'(read_signal), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_sop_eop", 32'({sop, eop}), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Packet 1, with a 5-cycle stall on beat 1.
        rst = 1'b0; enable = 1'b1; ready = 1'b1;
        push_beat(32'd0, 1'b1, 1'b0);
        push_beat(32'd1, 1'b0, 1'b0);
        push_beat(32'd2, 1'b0, 1'b0);
        push_beat(32'd3, 1'b0, 1'b1);
        wait_beats(1);
        ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_data", data, 32'd1);
            check("stall_valid", 32'(valid), 32'd1);
            check("stall_sop_eop", 32'({sop, eop}), 32'd0);
            check("stall_read", 32'(read_signal), 32'd0);
            check("stall_count", 32'(cnt), 32'd1);
            step();
        end
        ready = 1'b1;
        wait_beats(4);
        check("pkt1_count", 32'(pkt_count), 32'd1);

        // Packet 2 follows directly; enable drops mid-packet.
        push_beat(32'd4, 1'b1, 1'b0);
        push_beat(32'd5, 1'b0, 1'b0);
        push_beat(32'd6, 1'b0, 1'b0);
        push_beat(32'd7, 1'b0, 1'b1);
        wait_beats(6);
        enable = 1'b0;
        wait_beats(8);
        wait_idle();
        check("pkt2_valid", 32'(valid), 32'd0);
        check("pkt2_count", 32'(pkt_count), 32'd2);
        repeat (10) step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_beats", beats_seen, 32'd8);

        // Counter wrap appears as ordinary data.
        preload_val = 24'hFFFFFE;
        preload_en = 1'b1;
        step();
        preload_en = 1'b0;
        push_beat(32'h00FFFFFE, 1'b1, 1'b0);
        push_beat(32'h00FFFFFF, 1'b0, 1'b0);
        push_beat(32'h00000000, 1'b0, 1'b0);
        push_beat(32'h00000001, 1'b0, 1'b1);
        enable = 1'b1;
        wait_beats(9);
        enable = 1'b0;
        wait_beats(12);
        wait_idle();
        check("pkt3_count", 32'(pkt_count), 32'd3);

        // Reset while a beat is presented; the partial packet is dropped.
        ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        check("pre_rst_data", data, 32'd2);
        check("pre_rst_sop", 32'(sop), 32'd1);
        rst = 1'b1;
        step();
        exp_q.delete();
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_read", 32'(read_signal), 32'd0);
        check("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        push_beat(32'd0, 1'b1, 1'b0);
        push_beat(32'd1, 1'b0, 1'b0);
        push_beat(32'd2, 1'b0, 1'b0);
        push_beat(32'd3, 1'b0, 1'b1);
        wait_beats(14);
        enable = 1'b0;
        wait_beats(16);
        wait_idle();
        check("restart_pkt_count", 32'(pkt_count), 32'd1);

        // Single-beat packets with a 4-bit packet counter.
        enable2 = 1'b1;
        for (int i = 0; i < 300 && beats2 < 8; i++) step();
        check("len1_count8", 32'(pkt_count2), 32'd8);
        for (int i = 0; i < 300 && beats2 < 16; i++) step();
        enable2 = 1'b0;
        check("len1_beats", beats2, 32'd16);
        check("len1_wrap", 32'(pkt_count2), 32'd0);
        for (int i = 0; i < 100 && busy2; i++) step();
        check("len1_idle", 32'(busy2), 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
